// File: rtl/sd_audio_streamer.sv
// sd_audio_streamer: pulls consecutive SD sectors from sd_controller and pushes
// their bytes into the audio sample FIFO. A sector is requested only once the
// FIFO has room for all of it. Playback is one-shot or looped.
module sd_audio_streamer #(
  parameter int unsigned START_SECTOR = 0,
  parameter int unsigned NUM_SECTORS  = 2048,
  parameter int unsigned SECTOR_BYTES = 512,
  parameter int unsigned FIFO_DEPTH   = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        loop,
  input  logic        sd_ready,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  input  logic [10:0] fifo_count,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_din,
  output logic        busy,
  output logic        done,
  output logic [15:0] sector_index,
  output logic        overflow_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_ROOM = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_RECV      = 3'd3;
  localparam logic [2:0] S_NEXT      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [31:0] START_ADDR  = 32'(START_SECTOR * SECTOR_BYTES);
  localparam logic [31:0] SECTOR_STEP = 32'(SECTOR_BYTES);
  localparam logic [10:0] ROOM_LIMIT  = 11'(FIFO_DEPTH - SECTOR_BYTES);
  localparam logic [15:0] LAST_INDEX  = 16'(NUM_SECTORS);
  localparam int unsigned CNT_W       = $clog2(SECTOR_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SECTOR_BYTES);

  logic [2:0]       state;
  logic             byte_prev;
  logic [CNT_W-1:0] byte_cnt;
  logic             byte_edge;
  logic [15:0]      index_next;

  // Bytes beyond a full sector are dropped so the counter cannot wrap.
  assign byte_edge  = (state == S_RECV) && sd_byte_available && !byte_prev &&
                      (byte_cnt != CNT_FULL);
  assign index_next = sector_index + 16'd1;
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);

  // Previous sd_byte_available level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) byte_prev <= 1'b0;
    else       byte_prev <= sd_byte_available;
  end

  // FIFO write path: one registered write per byte edge, sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      overflow_err <= 1'b0;
    end else begin
      fifo_wr_en <= byte_edge;
      if (byte_edge) fifo_din <= sd_dout;
      if (fifo_wr_en && fifo_full) overflow_err <= 1'b1;
    end
  end

  // Sector sequencing: room check, read request, byte counting, advance/wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      sd_rd        <= 1'b0;
      sd_address   <= START_ADDR;
      sector_index <= '0;
      byte_cnt     <= '0;
    end else begin
      sd_rd <= 1'b0;
      if (byte_edge) byte_cnt <= byte_cnt + CNT_W'(1);
      case (state)
        S_IDLE: begin
          if (enable) begin
            // Keep the address consistent with the cleared sector offset.
            sector_index <= '0;
            sd_address   <= START_ADDR;
            state        <= S_WAIT_ROOM;
          end
        end
        S_WAIT_ROOM: begin
          if (!enable)                      state <= S_IDLE;
          else if (fifo_count <= ROOM_LIMIT) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (sd_ready) begin
            sd_rd    <= 1'b1;
            byte_cnt <= '0;
            state    <= S_RECV;
          end
        end
        S_RECV: begin
          // Wait for the last byte's write strobe to retire before moving on.
          if ((byte_cnt == CNT_FULL) && !fifo_wr_en && sd_ready) state <= S_NEXT;
        end
        S_NEXT: begin
          if (index_next == LAST_INDEX) begin
            if (loop) begin
              sector_index <= '0;
              sd_address   <= START_ADDR;
              state        <= S_WAIT_ROOM;
            end else begin
              sector_index <= index_next;
              sd_address   <= sd_address + SECTOR_STEP;
              state        <= S_DONE;
            end
          end else begin
            sector_index <= index_next;
            sd_address   <= sd_address + SECTOR_STEP;
            state        <= enable ? S_WAIT_ROOM : S_IDLE;
          end
        end
        S_DONE: begin
          if (!enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_audio_streamer.sv
// Self-checking bench for sd_audio_streamer: room-gate vector table, an SD
// controller model producing randomized byte streams, and a FIFO write
// scoreboard that checks data and one-cycle latency.
module tb_sd_audio_streamer;

  localparam int unsigned START = 3;
  localparam int unsigned NSEC  = 2;
  localparam int unsigned SB    = 512;
  localparam int unsigned NONE  = 100000;
  localparam logic [31:0] SA    = 32'(START * SB);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        loop = 1'b0;
  logic        sd_ready = 1'b0;
  logic        sd_byte_available = 1'b0;
  logic [7:0]  sd_dout = '0;
  logic [10:0] fifo_count = '0;
  logic        fifo_full = 1'b0;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        busy;
  logic        done;
  logic [15:0] sector_index;
  logic        overflow_err;

  sd_audio_streamer #(
    .START_SECTOR(START),
    .NUM_SECTORS (NSEC),
    .SECTOR_BYTES(SB),
    .FIFO_DEPTH  (2048)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .loop             (loop),
    .sd_ready         (sd_ready),
    .sd_rd            (sd_rd),
    .sd_address       (sd_address),
    .sd_byte_available(sd_byte_available),
    .sd_dout          (sd_dout),
    .fifo_count       (fifo_count),
    .fifo_full        (fifo_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_din         (fifo_din),
    .busy             (busy),
    .done             (done),
    .sector_index     (sector_index),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int unsigned nwritten = 0;

  typedef struct { logic [7:0] d; int unsigned c; } exp_t;
  exp_t        expq[$];
  logic [31:0] rdq[$];
  logic        prev_rd = 1'b0;

  typedef struct { logic [10:0] count; bit rd; } room_vec_t;
  room_vec_t room_tab[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard: every FIFO write must match the next expected byte and cycle.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      nwritten++;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected fifo write: data %0d at cycle %0d, none expected", fifo_din, cyc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (fifo_din !== e.d || cyc != e.c) begin
          failures++;
          $display("FAIL fifo write: data %0d cycle %0d, expected data %0d cycle %0d",
                   fifo_din, cyc, e.d, e.c);
        end
      end
    end
    if (sd_rd) begin
      rdq.push_back(sd_address);
      if (prev_rd) begin
        checks++;
        failures++;
        $display("FAIL sd_rd width: high %0d consecutive cycles, expected 1", 2);
      end
    end
    prev_rd = sd_rd;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input int unsigned budget, output bit got, output logic [31:0] addr);
    got = 1'b0;
    addr = '0;
    for (int unsigned i = 0; i < budget && !got; i++) begin
      tick();
      if (rdq.size() > 0) begin
        got = 1'b1;
        addr = rdq.pop_front();
      end
    end
  endtask

  task automatic wait_drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget && expq.size() > 0; i++) tick();
    check("pending writes drained", 32'(expq.size()), 0);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit full);
    int unsigned hi, lo;
    hi = full ? 2 : $urandom_range(1, 2);
    lo = $urandom_range(0, 1);
    tick();
    sd_byte_available = 1'b1;
    sd_dout = d;
    fifo_full = full;
    expq.push_back('{d, cyc + 1});
    repeat (hi) tick();
    sd_byte_available = 1'b0;
    sd_dout = 8'($urandom);
    fifo_full = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic serve_sector(input logic [31:0] exp_addr, input logic [15:0] idx_before,
                              input bit ramp, input int unsigned drop_at,
                              input int unsigned full_at);
    bit got;
    logic [31:0] a;
    wait_rd(40, got, a);
    check("sd_rd issued", 32'(got), 1);
    check("sd_address at sd_rd", a, exp_addr);
    check("sector_index during read", 32'(sector_index), 32'(idx_before));
    sd_ready = 1'b0;
    nwritten = 0;
    for (int unsigned i = 0; i < SB; i++) begin
      if (i == drop_at) enable = 1'b0;
      send_byte(ramp ? 8'(i) : 8'($urandom), i == full_at);
    end
    wait_drain(10);
    check("bytes written in sector", nwritten, SB);
    repeat (3) tick();
    check("index held until sd_ready", 32'(sector_index), 32'(idx_before));
    check("busy held until sd_ready", 32'(busy), 1);
    sd_ready = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " sd_rd"}, 32'(sd_rd), 0);
    check({tag, " sd_address"}, sd_address, SA);
    check({tag, " fifo_wr_en"}, 32'(fifo_wr_en), 0);
    check({tag, " fifo_din"}, 32'(fifo_din), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " sector_index"}, 32'(sector_index), 0);
    check({tag, " overflow_err"}, 32'(overflow_err), 0);
  endtask

  task automatic do_reset(input bit chk);
    tick();
    reset = 1'b1;
    enable = 1'b0;
    sd_byte_available = 1'b0;
    fifo_full = 1'b0;
    sd_ready = 1'b0;
    tick();
    tick();
    expq.delete();
    rdq.delete();
    if (chk) check_idle_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic room_case(input logic [10:0] count, input bit exp_rd);
    bit got;
    logic [31:0] a;
    do_reset(1);
    fifo_count = count;
    sd_ready = 1'b1;
    enable = 1'b1;
    wait_rd(12, got, a);
    check($sformatf("room gate count=%0d", count), 32'(got), 32'(exp_rd));
  endtask

  initial begin
    bit got;
    logic [31:0] a;
    logic [10:0] c;

    room_tab[0] = '{11'd0,    1'b1};
    room_tab[1] = '{11'd1000, 1'b1};
    room_tab[2] = '{11'd1536, 1'b1};
    room_tab[3] = '{11'd1537, 1'b0};
    room_tab[4] = '{11'd1800, 1'b0};
    room_tab[5] = '{11'd2047, 1'b0};

    do_reset(1);

    // Room gate: fixed table, then random occupancies against the room rule.
    for (int i = 0; i < 6; i++) room_case(room_tab[i].count, room_tab[i].rd);
    for (int i = 0; i < 6; i++) begin
      c = 11'($urandom_range(1400, 1700));
      room_case(c, c <= 11'(2048 - SB));
    end

    // One-shot clip: ramp sector, random sector, then done.
    do_reset(0);
    loop = 1'b0;
    fifo_count = '0;
    sd_ready = 1'b1;
    enable = 1'b1;
    serve_sector(SA, 16'd0, 1'b1, NONE, NONE);
    repeat (3) tick();
    check("index after sector 0", 32'(sector_index), 1);
    check("address after sector 0", sd_address, SA + SB);
    serve_sector(SA + SB, 16'd1, 1'b0, NONE, NONE);
    for (int i = 0; i < 10 && !done; i++) tick();
    check("done after last sector", 32'(done), 1);
    check("busy in done", 32'(busy), 0);
    check("index in done", 32'(sector_index), NSEC);
    check("address in done", sd_address, SA + 2 * SB);
    repeat (30) tick();
    check("no read after done", 32'(rdq.size()), 0);
    enable = 1'b0;
    tick();
    tick();
    check("done clears on disable", 32'(done), 0);

    // Looped clip: third read wraps to the first sector.
    do_reset(0);
    loop = 1'b1;
    sd_ready = 1'b1;
    enable = 1'b1;
    serve_sector(SA, 16'd0, 1'b0, NONE, NONE);
    serve_sector(SA + SB, 16'd1, 1'b0, NONE, NONE);
    wait_rd(40, got, a);
    check("loop third read", 32'(got), 1);
    check("loop wrap address", a, SA);
    check("loop wrap index", 32'(sector_index), 0);
    loop = 1'b0;

    // Room threshold edge while waiting on sd_ready; fifo_full without writes.
    do_reset(0);
    sd_ready = 1'b0;
    fifo_count = 11'd1537;
    fifo_full = 1'b1;
    enable = 1'b1;
    repeat (20) tick();
    check("no read at 1537", 32'(rdq.size()), 0);
    check("no overflow without write", 32'(overflow_err), 0);
    fifo_full = 1'b0;
    fifo_count = 11'd1536;
    repeat (5) tick();
    check("no read while sd not ready", 32'(rdq.size()), 0);
    sd_ready = 1'b1;
    wait_rd(2, got, a);
    check("read within 2 cycles of sd_ready", 32'(got), 1);
    fifo_count = '0;

    // Disable mid-sector: sector completes, then idle with no new read.
    do_reset(0);
    sd_ready = 1'b1;
    enable = 1'b1;
    serve_sector(SA, 16'd0, 1'b0, 100, NONE);
    repeat (4) tick();
    check("idle after disabled sector busy", 32'(busy), 0);
    check("idle after disabled sector done", 32'(done), 0);
    check("index after disabled sector", 32'(sector_index), 1);
    repeat (40) tick();
    check("no read after disable", 32'(rdq.size()), 0);

    // Overflow: FIFO full on the write of byte 10.
    do_reset(0);
    sd_ready = 1'b1;
    enable = 1'b1;
    serve_sector(SA, 16'd0, 1'b0, NONE, 10);
    check("overflow set", 32'(overflow_err), 1);
    repeat (4) tick();
    check("sector advanced after overflow", 32'(sector_index), 1);
    enable = 1'b0;
    repeat (40) tick();
    check("overflow sticky", 32'(overflow_err), 1);
    do_reset(1);

    // Reset mid-sector, edges outside RECV, restart from the first sector.
    sd_ready = 1'b1;
    enable = 1'b1;
    wait_rd(40, got, a);
    check("mid-reset first read", 32'(got), 1);
    check("mid-reset first address", a, SA);
    sd_ready = 1'b0;
    nwritten = 0;
    for (int unsigned i = 0; i < 300; i++) send_byte(8'($urandom), 1'b0);
    wait_drain(10);
    tick();
    reset = 1'b1;
    enable = 1'b0;
    tick();
    check_idle_outputs("mid-sector reset");
    reset = 1'b0;
    expq.delete();
    rdq.delete();
    sd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      sd_byte_available = 1'b1;
      tick();
      sd_byte_available = 1'b0;
    end
    repeat (3) tick();
    check("edges outside RECV ignored", nwritten, 300);
    enable = 1'b1;
    serve_sector(SA, 16'd0, 1'b1, NONE, NONE);
    do_reset(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
